// File: rtl/sound_envelope_pwm.sv
// Speaker output stage: attack/sustain/release envelope and PWM volume applied
// to the square-wave tone from the melody generator.
module sound_envelope_pwm #(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned STEP_DIV     = 50_000,
    parameter int unsigned SILENCE_CYC  = 100_000,
    parameter int unsigned ATTACK_STEP  = 8,
    parameter int unsigned RELEASE_STEP = 4
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    input  logic                iSOUND,
    input  logic [PWM_BITS-1:0] iVOL,
    input  logic                iMUTE,
    output logic                oSPK,
    output logic [PWM_BITS-1:0] oLEVEL,
    output logic                oBUSY
);

    localparam int unsigned SIL_W = $clog2(SILENCE_CYC + 1);
    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned LVL_W = PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_SUSTAIN,
        ST_RELEASE
    } state_t;

    state_t              state;
    logic                rSnd;
    logic [SIL_W-1:0]    silCnt;
    logic [DIV_W-1:0]    divCnt;
    logic [PWM_BITS-1:0] pwmCnt;

    logic             sndEdge;
    logic             silent;
    logic             tick;
    logic             pwmOn;
    logic [LVL_W-1:0] volExt;
    logic [LVL_W-1:0] lvlExt;
    logic [LVL_W-1:0] attSum;
    logic [LVL_W-1:0] attTick;
    logic [LVL_W-1:0] relTick;
    logic             attDone;

    assign sndEdge = iSOUND ^ rSnd;
    assign silent  = (silCnt == SIL_W'(SILENCE_CYC));
    assign tick    = (divCnt == DIV_W'(STEP_DIV - 1));
    assign pwmOn   = (pwmCnt < oLEVEL);

    // Saturating level arithmetic with one guard bit so nothing wraps.
    assign volExt  = {1'b0, iVOL};
    assign lvlExt  = {1'b0, oLEVEL};
    assign attSum  = lvlExt + LVL_W'(ATTACK_STEP);
    assign attTick = tick ? ((attSum >= volExt) ? volExt : attSum) : lvlExt;
    assign attDone = (attTick >= volExt);
    assign relTick = !tick ? lvlExt :
                     (lvlExt >= LVL_W'(RELEASE_STEP)) ? (lvlExt - LVL_W'(RELEASE_STEP)) : '0;

    // Tone input register, silence detector, step prescaler and PWM counter.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            rSnd   <= 1'b0;
            silCnt <= SIL_W'(SILENCE_CYC);
            divCnt <= '0;
            pwmCnt <= '0;
            oSPK   <= 1'b0;
        end else begin
            rSnd <= iSOUND;
            if (sndEdge) begin
                silCnt <= '0;
            end else if (!silent) begin
                silCnt <= silCnt + SIL_W'(1);
            end
            divCnt <= tick ? '0 : divCnt + DIV_W'(1);
            pwmCnt <= (pwmCnt == PWM_LAST) ? '0 : pwmCnt + PWM_BITS'(1);
            oSPK   <= rSnd & pwmOn & ~iMUTE;
        end
    end

    // Envelope FSM; oLEVEL and oBUSY are updated alongside the state.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state  <= ST_IDLE;
            oLEVEL <= '0;
            oBUSY  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    oLEVEL <= '0;
                    oBUSY  <= sndEdge;
                    if (sndEdge) begin
                        state <= ST_ATTACK;
                    end
                end
                ST_ATTACK: begin
                    oBUSY <= 1'b1;
                    if (silent) begin
                        state <= ST_RELEASE;
                    end else if (attDone) begin
                        state  <= ST_SUSTAIN;
                        oLEVEL <= iVOL;
                    end else begin
                        oLEVEL <= attTick[PWM_BITS-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    oBUSY  <= 1'b1;
                    oLEVEL <= iVOL;
                    if (silent) begin
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    // A new note resumes the attack from wherever the level is now.
                    if (sndEdge) begin
                        state <= ST_ATTACK;
                        oBUSY <= 1'b1;
                    end else begin
                        oLEVEL <= relTick[PWM_BITS-1:0];
                        if (relTick == '0) begin
                            state <= ST_IDLE;
                            oBUSY <= 1'b0;
                        end else begin
                            oBUSY <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    oLEVEL <= '0;
                    oBUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_envelope_pwm.sv
// Directed bench for sound_envelope_pwm: envelope steps, release timing,
// retrigger, volume tracking, PWM duty, mute and reset.
module tb_sound_envelope_pwm;

    localparam int unsigned PWM_BITS     = 4;
    localparam int unsigned STEP_DIV     = 4;
    localparam int unsigned SILENCE_CYC  = 20;
    localparam int unsigned ATTACK_STEP  = 3;
    localparam int unsigned RELEASE_STEP = 2;

    logic                iCLK = 1'b0;
    logic                iRST_N;
    logic                iSOUND;
    logic [PWM_BITS-1:0] iVOL;
    logic                iMUTE;
    logic                oSPK;
    logic [PWM_BITS-1:0] oLEVEL;
    logic                oBUSY;

    typedef struct {
        string               name;
        logic [PWM_BITS-1:0] lvl;
        int                  gap;
        logic                busy;
    } stepVec_t;

    stepVec_t attackTbl[5];
    stepVec_t releaseTbl[8];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   togCnt = 0;
    int   lastEdge = 0;
    bit   toggleEn = 1'b0;
    bit   chkSpk = 1'b0;
    logic lastSnd = 1'b0;

    sound_envelope_pwm #(
        .PWM_BITS    (PWM_BITS),
        .STEP_DIV    (STEP_DIV),
        .SILENCE_CYC (SILENCE_CYC),
        .ATTACK_STEP (ATTACK_STEP),
        .RELEASE_STEP(RELEASE_STEP)
    ) dut (
        .iCLK  (iCLK),
        .iRST_N(iRST_N),
        .iSOUND(iSOUND),
        .iVOL  (iVOL),
        .iMUTE (iMUTE),
        .oSPK  (oSPK),
        .oLEVEL(oLEVEL),
        .oBUSY (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample just after the edge, then advance the tone pattern.
    task automatic step();
        @(posedge iCLK);
        #1;
        cyc++;
        if (chkSpk) check("spk_delay2", 32'(oSPK), 32'(lastSnd));
        lastSnd = iSOUND;
        if (toggleEn) begin
            togCnt++;
            if (togCnt == 5) begin
                togCnt   = 0;
                iSOUND   = ~iSOUND;
                lastEdge = cyc + 1;
            end
        end
    endtask

    task automatic kick();
        iSOUND   = ~iSOUND;
        lastEdge = cyc + 1;
        togCnt   = 0;
    endtask

    task automatic waitLevel(input string name, input int bound, output int gap);
        logic [PWM_BITS-1:0] prev;
        int n;
        prev = oLEVEL;
        n = 0;
        do begin
            step();
            n++;
        end while (oLEVEL == prev && n < bound);
        check({name, "_changed"}, 32'(oLEVEL != prev), 32'd1);
        gap = n;
    endtask

    task automatic waitLevelIs(input string name, input logic [PWM_BITS-1:0] target, input int bound);
        int n;
        n = 0;
        while (oLEVEL != target && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(oLEVEL), 32'(target));
    endtask

    task automatic waitIdle(input string name, input int bound);
        int n;
        n = 0;
        while (oBUSY !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(oBUSY), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int gap;
        int d;
        int hi;

        attackTbl[0]  = '{"att_3", 4'd3, 0, 1'b1};
        attackTbl[1]  = '{"att_6", 4'd6, 4, 1'b1};
        attackTbl[2]  = '{"att_9", 4'd9, 4, 1'b1};
        attackTbl[3]  = '{"att_12", 4'd12, 4, 1'b1};
        attackTbl[4]  = '{"att_15", 4'd15, 4, 1'b1};
        releaseTbl[0] = '{"rel_13", 4'd13, 0, 1'b1};
        releaseTbl[1] = '{"rel_11", 4'd11, 4, 1'b1};
        releaseTbl[2] = '{"rel_9", 4'd9, 4, 1'b1};
        releaseTbl[3] = '{"rel_7", 4'd7, 4, 1'b1};
        releaseTbl[4] = '{"rel_5", 4'd5, 4, 1'b1};
        releaseTbl[5] = '{"rel_3", 4'd3, 4, 1'b1};
        releaseTbl[6] = '{"rel_1", 4'd1, 4, 1'b1};
        releaseTbl[7] = '{"rel_0", 4'd0, 4, 1'b0};

        iRST_N = 1'b0;
        iSOUND = 1'b0;
        iVOL   = 4'd15;
        iMUTE  = 1'b0;

        // Reset held while the tone toggles
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_spk", 32'(oSPK), 32'd0);
            check("rst_level", 32'(oLEVEL), 32'd0);
            check("rst_busy", 32'(oBUSY), 32'd0);
            if (i % 2 == 1) iSOUND = ~iSOUND;
        end
        iSOUND = 1'b0;
        iRST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_busy", 32'(oBUSY), 32'd0);
            check("idle_level", 32'(oLEVEL), 32'd0);
        end

        // Attack to full volume
        kick();
        toggleEn = 1'b1;
        step();
        check("busy_after_edge", 32'(oBUSY), 32'd1);
        check("level_at_note_on", 32'(oLEVEL), 32'd0);
        for (int i = 0; i < 5; i++) begin
            waitLevel(attackTbl[i].name, 3 * STEP_DIV, gap);
            check(attackTbl[i].name, 32'(oLEVEL), 32'(attackTbl[i].lvl));
            check({attackTbl[i].name, "_busy"}, 32'(oBUSY), 32'(attackTbl[i].busy));
            if (attackTbl[i].gap != 0) check({attackTbl[i].name, "_gap"}, 32'(gap), 32'(attackTbl[i].gap));
        end
        chkSpk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("sustain_15", 32'(oLEVEL), 32'd15);
        end

        // Mute silences the speaker but not the envelope
        chkSpk = 1'b0;
        iMUTE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mute_spk", 32'(oSPK), 32'd0);
            check("mute_level", 32'(oLEVEL), 32'd15);
        end
        iMUTE = 1'b0;
        step();
        chkSpk = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Release after the silence gap
        chkSpk = 1'b0;
        toggleEn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            waitLevel(releaseTbl[i].name, 40, gap);
            if (i == 0) begin
                d = cyc - lastEdge;
                check("release_onset_window", 32'(d >= 22 && d <= 25), 32'd1);
            end
            check(releaseTbl[i].name, 32'(oLEVEL), 32'(releaseTbl[i].lvl));
            check({releaseTbl[i].name, "_busy"}, 32'(oBUSY), 32'(releaseTbl[i].busy));
            if (releaseTbl[i].gap != 0) check({releaseTbl[i].name, "_gap"}, 32'(gap), 32'(releaseTbl[i].gap));
        end

        // Retrigger during release, edge coinciding with a step tick
        kick();
        toggleEn = 1'b1;
        waitLevelIs("note2_peak", 4'd15, 40);
        toggleEn = 1'b0;
        waitLevelIs("note2_rel_9", 4'd9, 60);
        for (int i = 0; i < 3; i++) step();
        kick();
        toggleEn = 1'b1;
        step();
        check("retrig_hold_9", 32'(oLEVEL), 32'd9);
        check("retrig_busy", 32'(oBUSY), 32'd1);
        waitLevel("retrig_12", 3 * STEP_DIV, gap);
        check("retrig_12", 32'(oLEVEL), 32'd12);
        check("retrig_12_gap", 32'(gap), 32'd4);
        waitLevel("retrig_15", 3 * STEP_DIV, gap);
        check("retrig_15", 32'(oLEVEL), 32'd15);
        check("retrig_15_gap", 32'(gap), 32'd4);

        // Volume change tracks immediately in sustain
        iVOL = 4'd6;
        step();
        check("vol_track_6", 32'(oLEVEL), 32'd6);

        // PWM duty with the tone held high
        toggleEn = 1'b0;
        if (iSOUND) begin
            iSOUND = 1'b0;
            step();
        end
        iSOUND = 1'b1;
        step();
        step();
        step();
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (oSPK) hi++;
        end
        check("pwm_duty_6of15", 32'(hi), 32'd6);
        check("pwm_level_6", 32'(oLEVEL), 32'd6);
        waitIdle("vol6_release_idle", 80);

        // Reset in the middle of an attack
        iVOL = 4'd15;
        kick();
        toggleEn = 1'b1;
        waitLevelIs("att2_3", 4'd3, 12);
        iRST_N = 1'b0;
        step();
        check("midrst_level", 32'(oLEVEL), 32'd0);
        check("midrst_busy", 32'(oBUSY), 32'd0);
        check("midrst_spk", 32'(oSPK), 32'd0);
        iRST_N = 1'b1;
        toggleEn = 1'b0;
        iSOUND = 1'b0;
        step();
        check("postrst_busy", 32'(oBUSY), 32'd0);

        // Zero volume: note plays at level 0 and then ends
        iVOL = 4'd0;
        kick();
        step();
        check("vol0_busy", 32'(oBUSY), 32'd1);
        check("vol0_level", 32'(oLEVEL), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("vol0_sustain_level", 32'(oLEVEL), 32'd0);
            check("vol0_spk", 32'(oSPK), 32'd0);
        end
        waitIdle("vol0_idle", 40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_envelope_pwm.md
Name: sound_envelope_pwm

Overview:
- Output stage that sits directly downstream of the melody tone generator; consumes its square-wave sound signal and drives the speaker pin.
- Applies a note envelope (attack / sustain / release) and a PWM volume level to the raw tone, so note boundaries stop clicking and loudness is controllable.
- Note-on is the first tone edge; note-off is a silence gap with no edges.

Parameters:
- PWM_BITS, 8, width of the volume level and the PWM counter.
- STEP_DIV, 50_000, iCLK cycles per envelope step tick.
- SILENCE_CYC, 100_000, cycles without an iSOUND edge before note-off. Must exceed the longest tone half-period; the melody table maximum is 47_774.
- ATTACK_STEP, 8, level increment per tick in ATTACK.
- RELEASE_STEP, 4, level decrement per tick in RELEASE.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  reset; synchronous and active-low.
- iSOUND  in  1  square-wave tone from the upstream tone generator, same clock domain.
- iVOL  in  PWM_BITS  target (sustain) volume level.
- iMUTE  in  1  forces speaker output low; envelope keeps running.
- oSPK  out  1  envelope-shaped, PWM-gated tone to the speaker.
- oLEVEL  out  PWM_BITS  current envelope level.
- oBUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (iRST_N=0 at a rising edge of iCLK):
  - state=IDLE; oLEVEL=0, oSPK=0, oBUSY=0.
  - rSND=0; PWM counter and step prescaler cleared.
  - Silence counter loaded with SILENCE_CYC, so the tone is inactive.
  - Reset takes effect mid-operation the same way, with outputs zero on the next cycle.
- Input register: rSND <= iSOUND. edge = (iSOUND != rSND).
- Silence counter:
  - Cleared to 0 on edge.
  - Otherwise increments, saturating at SILENCE_CYC.
  - silent = (counter == SILENCE_CYC).
- Step tick: free-running prescaler 0..STEP_DIV-1. tick=1 for one cycle when it wraps. It is never reset by FSM activity.
- Level arithmetic: use PWM_BITS+1 bits internally. Both additions and subtractions saturate, to iVOL and to 0 respectively; no wrap is permitted.
- FSM, evaluated every cycle:
  - IDLE: level=0. On edge, go to ATTACK.
  - ATTACK:
    - On tick, level=min(level+ATTACK_STEP, iVOL).
    - If level>=iVOL, set level=iVOL and go to SUSTAIN. This covers iVOL lowered below the current level.
    - If silent, go to RELEASE; silent takes priority over tick.
  - SUSTAIN:
    - level=iVOL every cycle, so volume changes track immediately.
    - If silent, go to RELEASE.
  - RELEASE:
    - On tick, level=max(level-RELEASE_STEP, 0).
    - When level reaches 0, go to IDLE.
    - An edge in RELEASE goes to ATTACK from the current level, not from 0. The edge takes priority over the tick in that cycle.
  - iVOL=0: ATTACK goes straight to SUSTAIN at level 0.
- PWM:
  - Counter runs 0..2^PWM_BITS-2 and wraps; period is 2^PWM_BITS-1.
  - pwm_on = (counter < level). Level max gives 100% duty; level 0 gives 0%.
- Output: oSPK <= rSND & pwm_on & ~iMUTE, registered. Latency from iSOUND to oSPK is 2 cycles.
- oLEVEL and oBUSY are registered from the FSM. iMUTE has no effect on them.

Test Plan:
Bench parameters: PWM_BITS=4, STEP_DIV=4, SILENCE_CYC=20, ATTACK_STEP=3, RELEASE_STEP=2.
- Reset: hold iRST_N=0 for 5 cycles while iSOUND toggles every 2 cycles -> oSPK=0, oLEVEL=0, oBUSY=0 throughout.
- Attack:
  - Stimulus: iVOL=15, iSOUND toggles every 5 cycles.
  - Required: oBUSY=1 the cycle after the first edge.
  - Required: oLEVEL steps 3,6,9,12,15 on successive ticks, then holds 15 (SUSTAIN).
  - Required: oSPK equals iSOUND delayed 2 cycles.
- Release:
  - Stimulus: stop toggling.
  - Required: RELEASE entered 20 cycles after the last edge.
  - Required: oLEVEL goes 13,11,9,7,5,3,1,0 on ticks, then IDLE with oBUSY=0.
- Retrigger: edge arrives while in RELEASE at level 9 -> ATTACK; oLEVEL goes 12 then 15, with no drop to 0.
- Volume and PWM:
  - Stimulus: in SUSTAIN, iVOL changes 15->6.
  - Required: oLEVEL=6 on the next cycle.
  - Required: while iSOUND is held 1, oSPK is high 6 of every 15 cycles.
- Mute and reset:
  - iMUTE=1 during SUSTAIN -> oSPK=0 while oLEVEL is unchanged.
  - iRST_N=0 mid-ATTACK -> oLEVEL=0, oBUSY=0, oSPK=0 on the next cycle.
